md_div_unit: RTL and testbench

- Parametrised iterative integer divider for the EX stage; successor to the fixed 32-bit start/ready divider.
- Generalises operand width.
- Adds:
  - valid/ready handshakes on both the input side and the result side.
  - An explicit divide-by-zero flag.
  - Defined results for the signed-overflow case.
  - Result holding under back-pressure.
- EX drives operands from rf_rdata1/rf_rdata2 and stalls the pipeline until out_valid. The 2*WIDTH result maps onto the hi/lo write bus: hi = remainder, lo = quotient.

---
 rtl/md_div_unit.sv | 159 +++++++++++++++
 tb/tb_md_div_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_div_unit.sv
// ============================================================================
//  Module   : md_div_unit
//  Purpose  : Iterative restoring radix-2 signed/unsigned integer divider with
//             valid/ready handshakes, a divide-by-zero flag and annul.
//             Optional DIV_EARLY_OUT_EN skips leading-zero dividend bits.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module md_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 annul,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_prem;
    logic [WIDTH-1:0]     r_dvd;      // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0]     r_dsr;
    logic [WIDTH-1:0]     r_raw;
    logic                 r_sign_q;
    logic                 r_sign_r;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_dbz;

    logic [WIDTH-1:0]     w_dvd_mag;
    logic [WIDTH-1:0]     w_dsr_mag;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;

    assign w_dvd_mag = (op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dsr_mag = (op_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // A negative WIDTH+1-bit difference means the trial subtract failed.
    assign w_shift = {r_prem, r_dvd[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dsr};

    assign w_q_fix = r_sign_q ? -r_dvd  : r_dvd;
    assign w_r_fix = r_sign_r ? -r_prem : r_prem;

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] w_lz;

    always_comb begin
        w_lz = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (r_dvd[i]) begin
                w_lz = CNT_W'(WIDTH - 1 - i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_prem   <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_raw    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else if (annul && r_state != S_IDLE) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && !annul) begin
                        r_sign_q <= op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_sign_r <= op_signed & dividend[WIDTH-1];
                        r_dvd    <= w_dvd_mag;
                        r_dsr    <= w_dsr_mag;
                        r_raw    <= dividend;
                        r_state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (r_dsr == '0) begin
                        r_result <= {r_raw, {WIDTH{1'b1}}};
                        r_dbz    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_prem <= '0;
                        r_dbz  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
                        // Leading zeros only contribute zero quotient bits.
                        if (w_lz == CNT_W'(WIDTH)) begin
                            r_state <= S_FIX;
                        end else begin
                            r_dvd   <= r_dvd << w_lz;
                            r_cnt   <= w_lz;
                            r_state <= S_CALC;
                        end
`else
                        r_cnt   <= '0;
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_prem  <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_dvd   <= {r_dvd[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= {w_r_fix, w_q_fix};
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_result;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_md_div_unit.sv
// ============================================================================
//  Module   : tb_md_div_unit
//  Purpose  : Self-checking bench for md_div_unit (WIDTH=32): vector table,
//             randomized ops against an arithmetic model, handshake corners.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_div_unit;

    localparam int W = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            op_signed;
    logic [W-1:0]    dividend;
    logic [W-1:0]    divisor;
    logic            annul;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  result;
    logic            div_by_zero;

    md_div_unit #(.WIDTH(W), .CNT_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_signed   (op_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .annul       (annul),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_res;
        logic           exp_dbz;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain language-level division, truncating toward zero.
    function automatic logic [2*W:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [W-1:0] qq, rr;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qq = q[W-1:0];
        rr = r[W-1:0];
        return {1'b0, rr, qq};
    endfunction

`ifdef DIV_EARLY_OUT_EN
    function automatic int lead_zeros(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return W - 1 - i;
        end
        return W;
    endfunction
`endif

    // Edges counted from the accept edge (inclusive) until out_valid is seen.
    function automatic int exp_latency(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] mag;
        mag = (sgn && a[W-1]) ? -a : a;
        if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
        return W - lead_zeros(mag) + 3;
`else
        return (mag == mag) ? W + 3 : 0;
`endif
    endfunction

    task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] res, output logic dbz, output int lat);
        @(negedge clk);
        op_signed = sgn;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            dividend  = $urandom;
            divisor   = $urandom;
            op_signed = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = result;
        dbz = div_by_zero;
    endtask

    vec_t             vecs[12];
    logic [2*W-1:0]   res;
    logic             dbz;
    logic [2*W:0]     m;
    int               lat;
    logic             seen;
    logic             sgn;
    logic [W-1:0]     a, b;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0};
        vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b0};
        vecs[3]  = '{1'b0, 32'h12345678,   32'd0,        {32'h12345678, 32'hFFFFFFFF}, 1'b1};
        vecs[4]  = '{1'b0, 32'd9,          32'd3,        {32'h00000000, 32'h00000003}, 1'b0};
        vecs[5]  = '{1'b0, 32'd5,          32'd1,        {32'h00000000, 32'h00000005}, 1'b0};
        vecs[6]  = '{1'b0, 32'd0,          32'd5,        {32'h00000000, 32'h00000000}, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h00000000, 32'hFFFFFFFF}, 1'b0};
        vecs[8]  = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b0};
        vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 1'b1};
        vecs[11] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 1'b0};

        rst = 1'b1; in_valid = 1'b0; op_signed = 1'b0; dividend = '0; divisor = '0;
        annul = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready",  64'(in_ready),    64'd1);
        check("reset_busy",      64'(busy),        64'd0);
        check("reset_out_valid", 64'(out_valid),   64'd0);
        check("reset_result",    result,           64'd0);
        check("reset_dbz",       64'(div_by_zero), 64'd0);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, res, dbz, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vecs[i].exp_dbz));
            check($sformatf("vec%0d_latency", i), 64'(lat),
                  64'(exp_latency(vecs[i].sgn, vecs[i].a, vecs[i].b)));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_consumed", i), 64'({out_valid, in_ready}), 64'b01);
        end

        for (int i = 0; i < 80; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin sgn = 1'b1; a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                3: a = a >> $urandom_range(0, 31);
                4: b = b >> $urandom_range(16, 31);
                default: ;
            endcase
            m = model(sgn, a, b);
            do_op(sgn, a, b, res, dbz, lat);
            check($sformatf("rnd%0d_result s=%0d a=%h b=%h", i, sgn, a, b), res, m[2*W-1:0]);
            check($sformatf("rnd%0d_dbz", i), 64'(dbz), 64'(m[2*W]));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_latency(sgn, a, b)));
        end
        @(negedge clk);

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        do_op(1'b0, 32'd100, 32'd7, res, dbz, lat);
        check("bp_first", res, {32'h2, 32'hE});
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold%0d", k), {61'd0, out_valid, in_ready, div_by_zero}, 64'b100);
            check($sformatf("bp_result%0d", k), result, {32'h2, 32'hE});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release", 64'({out_valid, in_ready}), 64'b01);

        // annul in DONE while held counts as consumed.
        out_ready = 1'b0;
        do_op(1'b0, 32'd50, 32'd5, res, dbz, lat);
        check("annul_done_res", res, {32'h0, 32'hA});
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        out_ready = 1'b1;
        check("annul_done_idle", 64'({out_valid, in_ready, busy}), 64'b010);

        // annul in IDLE blocks acceptance.
        in_valid = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3; op_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; annul = 1'b0;
        check("annul_idle_busy", 64'(busy), 64'd0);

        // annul mid-CALC.
        in_valid = 1'b1; dividend = 32'hFFFFFFF0; divisor = 32'd3; op_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (13) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("annul_calc_busy_before", 64'(busy), 64'd1);
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        check("annul_calc_state", 64'({busy, out_valid, in_ready, seen}), 64'b0010);
        do_op(1'b0, 32'd9, 32'd3, res, dbz, lat);
        check("after_annul_res", res, {32'h0, 32'h3});
        check("after_annul_lat", 64'(lat), 64'(exp_latency(1'b0, 32'd9, 32'd3)));

        // Asynchronous reset mid-CALC, checked before any clock edge.
        @(negedge clk);
        in_valid = 1'b1; dividend = 32'hFFFFFFF0; divisor = 32'd7; op_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("arst_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_outputs", {result[61:0], div_by_zero, out_valid}, 64'd0);
        check("arst_result_hi", 64'(result[63:62]), 64'd0);
        check("arst_ready", 64'({in_ready, busy}), 64'b10);
        rst = 1'b0;
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, res, dbz, lat);
        check("post_arst_res", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
